// File: rtl/sound_controller.sv
// Game sound sequencer: wall/hit/goal tones with priority preemption,
// goal as two tones separated by a silent gap, and a speaker mute.
module sound_controller #(
    parameter int unsigned HIT_HALF   = 25000,
    parameter int unsigned WALL_HALF  = 50000,
    parameter int unsigned GOAL_HALF1 = 12500,
    parameter int unsigned GOAL_HALF2 = 25000,
    parameter int unsigned HIT_LEN    = 1250000,
    parameter int unsigned WALL_LEN   = 625000,
    parameter int unsigned GOAL_LEN   = 2500000,
    parameter int unsigned GAP_LEN    = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       wall,
    input  logic       goal,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] sound_id
);

    typedef enum logic [2:0] {
        IDLE, WALL, HIT, GOAL1, GAP, GOAL2
    } state_t;

    state_t      state, nstate;
    logic [16:0] hcnt, nhcnt;
    logic [21:0] dcnt, ndcnt;
    logic        phase, nphase;
    logic [1:0]  cur_pri, evt_pri;
    logic [16:0] half_m1;
    logic [21:0] len_m1;
    state_t      after;

    always_comb begin
        evt_pri = 2'd0;
        if (goal)      evt_pri = 2'd3;
        else if (hit)  evt_pri = 2'd2;
        else if (wall) evt_pri = 2'd1;
    end

    // Per-state tone period, duration and successor.
    always_comb begin
        cur_pri = 2'd3;
        half_m1 = 17'(GOAL_HALF1 - 1);
        len_m1  = 22'(GOAL_LEN - 1);
        after   = GAP;
        unique case (state)
            IDLE: cur_pri = 2'd0;
            WALL: begin
                cur_pri = 2'd1;
                half_m1 = 17'(WALL_HALF - 1);
                len_m1  = 22'(WALL_LEN - 1);
                after   = IDLE;
            end
            HIT: begin
                cur_pri = 2'd2;
                half_m1 = 17'(HIT_HALF - 1);
                len_m1  = 22'(HIT_LEN - 1);
                after   = IDLE;
            end
            GOAL1: ;
            GAP: begin
                len_m1 = 22'(GAP_LEN - 1);
                after  = GOAL2;
            end
            GOAL2: begin
                half_m1 = 17'(GOAL_HALF2 - 1);
                after   = IDLE;
            end
            default: ;
        endcase
    end

    always_comb begin
        nstate = state;
        nhcnt  = hcnt;
        ndcnt  = dcnt;
        nphase = phase;
        if (evt_pri != 2'd0 && evt_pri >= cur_pri) begin
            nhcnt  = '0;
            ndcnt  = '0;
            nphase = 1'b0;
            unique case (evt_pri)
                2'd3:    nstate = GOAL1;
                2'd2:    nstate = HIT;
                default: nstate = WALL;
            endcase
        end else if (state != IDLE) begin
            if (dcnt == len_m1) begin
                nstate = after;
                nhcnt  = '0;
                ndcnt  = '0;
                nphase = 1'b0;
            end else begin
                ndcnt = dcnt + 22'd1;
                if (state == GAP) begin
                    nphase = 1'b0;
                end else if (hcnt == half_m1) begin
                    nhcnt  = '0;
                    nphase = ~phase;
                end else begin
                    nhcnt = hcnt + 17'd1;
                end
            end
        end
    end

    // Outputs are registered from next-state so they align with the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hcnt     <= '0;
            dcnt     <= '0;
            phase    <= 1'b0;
            speaker  <= 1'b0;
            busy     <= 1'b0;
            sound_id <= 2'b00;
        end else begin
            state   <= nstate;
            hcnt    <= nhcnt;
            dcnt    <= ndcnt;
            phase   <= nphase;
            speaker <= nphase & ~mute;
            busy    <= (nstate != IDLE);
            unique case (nstate)
                IDLE:    sound_id <= 2'b00;
                WALL:    sound_id <= 2'b01;
                HIT:     sound_id <= 2'b10;
                default: sound_id <= 2'b11;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_controller.sv
// Random and directed stimulus for sound_controller, compared each cycle
// against an elapsed-time model of the sound sequences.
module tb_sound_controller;

    localparam int HH = 4, WH = 8, G1 = 2, G2 = 4;
    localparam int HL = 40, WL = 32, GL = 20, GP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hit = 1'b0, wall = 1'b0, goal = 1'b0, mute = 1'b0;
    logic       speaker, busy;
    logic [1:0] sound_id;

    int checks = 0;
    int errors = 0;

    int m_snd = 0;
    int m_t   = 0;
    bit m_mp  = 1'b0;
    bit chk_en = 1'b0;

    sound_controller #(
        .HIT_HALF(HH), .WALL_HALF(WH),
        .GOAL_HALF1(G1), .GOAL_HALF2(G2),
        .HIT_LEN(HL), .WALL_LEN(WL),
        .GOAL_LEN(GL), .GAP_LEN(GP)
    ) dut (
        .clk(clk), .rst(rst),
        .hit(hit), .wall(wall), .goal(goal),
        .mute(mute),
        .speaker(speaker), .busy(busy),
        .sound_id(sound_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic int total_len(input int s);
        case (s)
            1: return WL;
            2: return HL;
            3: return 2 * GL + GP;
            default: return 0;
        endcase
    endfunction

    function automatic int raw_wave(input int s, input int t);
        case (s)
            1: return (t / WH) % 2;
            2: return (t / HH) % 2;
            3: begin
                if (t < GL) return (t / G1) % 2;
                if (t < GL + GP) return 0;
                return ((t - GL - GP) / G2) % 2;
            end
            default: return 0;
        endcase
    endfunction

    // Model: which sound is playing and how long since it started.
    always @(posedge clk) begin
        int p;
        p = goal ? 3 : hit ? 2 : wall ? 1 : 0;
        if (rst) begin
            m_snd = 0;
            m_t   = 0;
        end else if (p != 0 && p >= m_snd) begin
            m_snd = p;
            m_t   = 0;
        end else if (m_snd != 0) begin
            m_t++;
            if (m_t >= total_len(m_snd)) begin
                m_snd = 0;
                m_t   = 0;
            end
        end
        m_mp = mute;
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(m_snd != 0));
            check("sound_id", int'(sound_id), m_snd);
            check("speaker", int'(speaker),
                  m_mp ? 0 : raw_wave(m_snd, m_t));
        end
    end

    task automatic drive(input bit h, input bit w, input bit g,
                         input bit m, input bit r);
        @(posedge clk);
        #1;
        hit = h; wall = w; goal = g; mute = m; rst = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_id", int'(sound_id), 0);
        check("reset_spk", int'(speaker), 0);

        drive(1, 0, 0, 0, 0);
        idle(60);
        drive(0, 0, 1, 0, 0);
        idle(60);
        drive(1, 1, 1, 0, 0);
        idle(60);

        drive(0, 1, 0, 0, 0);
        idle(4);
        drive(1, 0, 0, 0, 0);
        idle(14);
        drive(0, 1, 0, 0, 0);
        idle(50);

        drive(1, 0, 0, 0, 0);
        idle(9);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0);
        idle(50);

        drive(0, 0, 1, 0, 0);
        idle(24);
        drive(1, 0, 0, 0, 1);
        idle(4);
        drive(1, 0, 0, 0, 0);
        idle(60);

        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 29) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 299) == 0);
        end
        idle(80);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_controller.md
SOUND_CONTROLLER -- requirements
Module: sound_controller

Interface
REQ-001 Parameter HIT_HALF, default 25000; tone half-period in clocks for the hit sound (500 Hz at 25 MHz).
REQ-002 Parameter WALL_HALF, default 50000; wall tone half-period (250 Hz).
REQ-003 Parameter GOAL_HALF1, default 12500; first goal tone half-period (1 kHz).
REQ-004 Parameter GOAL_HALF2, default 25000; second goal tone half-period (500 Hz).
REQ-005 Parameters HIT_LEN 1250000, WALL_LEN 625000, GOAL_LEN 2500000, GAP_LEN 500000; durations in clocks.
REQ-006 clk  in  1  system clock; one clock domain; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 hit  in  1  one-cycle paddle-collision pulse from the game controller.
REQ-009 wall  in  1  one-cycle wall-collision pulse.
REQ-010 goal  in  1  one-cycle goal pulse.
REQ-011 mute  in  1  level; 1 silences speaker, sequencing continues.
REQ-012 speaker  out  1  registered square-wave audio output.
REQ-013 busy  out  1  registered; 1 while any sound state is active.
REQ-014 sound_id  out  2  registered; 00 none, 01 wall, 10 hit, 11 goal.

Function
REQ-015 FSM states SHALL be IDLE, WALL, HIT, GOAL1, GAP, GOAL2.
REQ-016 Priority SHALL be goal > hit > wall; simultaneous pulses start only the highest.
REQ-017 Event pulse sampled high in cycle N SHALL place FSM in the tone state at N+1 with busy=1, sound_id set, speaker=0, half-period and duration counters cleared.
REQ-018 In a tone state, half-period counter SHALL increment each clock; on reaching HALF-1 it clears and speaker toggles (first toggle at N+1+HALF).
REQ-019 Duration counter SHALL increment each clock; tone state lasts exactly LEN cycles, then HIT/WALL -> IDLE, GOAL1 -> GAP, GAP -> GOAL2 (after GAP_LEN), GOAL2 -> IDLE (after GOAL_LEN).
REQ-020 In GAP, speaker SHALL be 0, busy=1, sound_id=11.
REQ-021 In IDLE, speaker=0, busy=0, sound_id=00.
REQ-022 Pulse of strictly higher priority than the active sound SHALL preempt: restart as REQ-017 in the new sound's first state.
REQ-023 Pulse of equal priority SHALL restart the active sound from its first state (goal restarts at GOAL1 from GAP or GOAL2).
REQ-024 Pulse of lower priority SHALL be ignored; no queueing.
REQ-025 mute=1 SHALL force speaker=0 in the same registered cycle; FSM, counters, busy, sound_id unaffected; releasing mute resumes the current waveform phase.
REQ-026 Counters: half-period 17 bits, duration 22 bits, unsigned, never wrap within legal parameters; HALF>=2 and LEN>=1 required.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, speaker=0, busy=0, sound_id=00, all counters 0, regardless of state or concurrent pulses.
REQ-028 Pulses in the reset cycle SHALL be discarded; first pulse after reset release is honoured per REQ-017.

Verification (parameters HIT_HALF=4, WALL_HALF=8, GOAL_HALF1=2, GOAL_HALF2=4, HIT_LEN=40, WALL_LEN=32, GOAL_LEN=20, GAP_LEN=10)
REQ-029 hit pulse at cycle 10 -> busy=1, sound_id=10 at 11-50; speaker toggles at 15,19,...; busy=0 at 51.
REQ-030 goal pulse at 0 -> GOAL1 1-20 (toggle every 2), GAP 21-30 speaker=0, GOAL2 31-50 (toggle every 4), IDLE at 51.
REQ-031 hit, wall, goal all pulsed same cycle -> only goal sequence plays, sound_id=11.
REQ-032 wall at 0, hit at 5 -> hit preempts at 6, lasts to 45; wall at 20 ignored, sound_id stays 10.
REQ-033 hit at 0, mute high 10-19 -> speaker 0 during 10-19, busy=1, sound_id=10, toggling resumes in original phase at 20.
REQ-034 goal at 0, rst at 25 -> cycle 26 IDLE, busy=0, speaker=0; hit at 30 plays normally from 31.
